smart_led_tx_encoder: RTL and testbench

- Serialises 24-bit GRB pixel words into a WS2812-style one-wire NRZ pulse stream (`dout`) that drives a smart-LED chain.
- It is the transmit end of the one-wire stream consumed by the LED receive path.
- Pixels arrive through a valid/ready handshake. Back-to-back pixels are sent without gaps.
- A frame ends automatically with a low latch period once no new pixel is offered.

---
 rtl/smart_led_tx_encoder.sv | 114 +++++++++++
 tb/tb_smart_led_tx_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/smart_led_tx_encoder.sv
// WS2812-style one-wire NRZ transmitter.
// Pixel words arrive over valid/ready and are sent MSB first. Each bit lasts TBIT cycles with a
// high time of T0H or T1H. Back-to-back pixels run with no gap, and a TRES-cycle low latch
// closes the frame.
module smart_led_tx_encoder #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned T0H   = 8,
  parameter int unsigned T1H   = 16,
  parameter int unsigned TBIT  = 25,
  parameter int unsigned TRES  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             dout,
  output logic             busy
);

  if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && TRES >= 1)) begin : g_param_check
    $fatal(1, "smart_led_tx_encoder: illegal timing parameters");
  end

  localparam int unsigned CntMax = (TBIT > TRES) ? TBIT : TRES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CntW-1:0] TbitLast = CntW'(TBIT - 1);
  localparam logic [CntW-1:0] TresLast = CntW'(TRES - 1);
  localparam logic [CntW-1:0] T0hCnt   = CntW'(T0H);
  localparam logic [CntW-1:0] T1hCnt   = CntW'(T1H);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBit, StLatch} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dout_q, dout_d;

  // State, shift register, counters and the registered line driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state, handshake and line level for the next cycle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    // The line follows the counter one cycle later, so the first rise is one edge after transfer.
    dout_d  = (state_q == StBit) && (cnt_q < (shreg_q[WIDTH-1] ? T1hCnt : T0hCnt));
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (valid) begin
          state_d = StBit;
          shreg_d = data_in;
          idx_d   = IdxLast;
          cnt_d   = '0;
        end
      end
      StBit: begin
        if (cnt_q == TbitLast) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            shreg_d = shreg_q << 1;
            idx_d   = idx_q - IdxW'(1);
          end else begin
            // Last cycle of the last bit: a new pixel can be chained here without a gap.
            ready = 1'b1;
            if (valid) begin
              shreg_d = data_in;
              idx_d   = IdxLast;
            end else begin
              state_d = StLatch;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        if (cnt_q == TresLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout = dout_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_smart_led_tx_encoder.sv
// Directed bench for smart_led_tx_encoder: default-timing instance plus a fast-timing instance.
module tb_smart_led_tx_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b, dout_a, dout_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Per-run traces; index i holds the value sampled 1 time unit after edge i of the run.
  logic sd[0:3999];
  logic sr[0:3999];
  logic sb[0:3999];
  int   xt[0:7];
  int   nx;
  int   pq[0:3];
  int   vs[0:3];
  int   npix;

  smart_led_tx_encoder u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_a),
    .valid   (valid_a),
    .ready   (ready_a),
    .dout    (dout_a),
    .busy    (busy_a)
  );

  smart_led_tx_encoder #(
    .WIDTH (24),
    .T0H   (2),
    .T1H   (4),
    .TBIT  (6),
    .TRES  (10)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_b),
    .valid   (valid_b),
    .ready   (ready_b),
    .dout    (dout_b),
    .busy    (busy_b)
  );

  always #5 clk = ~clk;

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers pq[i] from loop step vs[i] onward (never before the previous transfer), recording
  // traces and the edge index of each transfer.
  task automatic run(input int sel, input int ncyc);
    logic hs;
    nx = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (nx < npix && k >= vs[nx]) begin
        if (sel == 0) begin valid_a = 1'b1; data_a = pq[nx][23:0]; end
        else begin valid_b = 1'b1; data_b = pq[nx][23:0]; end
      end
      hs = (sel == 0) ? (valid_a && ready_a) : (valid_b && ready_b);
      @(posedge clk);
      #1;
      sd[k+1] = (sel == 0) ? dout_a : dout_b;
      sr[k+1] = (sel == 0) ? ready_a : ready_b;
      sb[k+1] = (sel == 0) ? busy_a : busy_b;
      if (hs) begin
        xt[nx] = k + 1;
        nx++;
        if (sel == 0) valid_a = 1'b0; else valid_b = 1'b0;
      end
    end
  endtask

  // Decodes nbits from the dout trace starting at sample s0; bad counts malformed bit windows.
  task automatic decode(input int sel, input int s0, input int nbits,
                        output logic [71:0] w, output int bad);
    int t0, t1, tb, h;
    logic lead;
    t0 = (sel == 0) ? 8 : 2;
    t1 = (sel == 0) ? 16 : 4;
    tb = (sel == 0) ? 25 : 6;
    w = '0;
    bad = 0;
    for (int b = 0; b < nbits; b++) begin
      h = 0;
      lead = 1'b1;
      for (int c = 0; c < tb; c++) begin
        if (sd[s0 + b*tb + c]) begin
          if (lead) h++; else bad++;
        end else begin
          lead = 1'b0;
        end
      end
      if (h == t1) w = {w[70:0], 1'b1};
      else begin
        if (h != t0) bad++;
        w = {w[70:0], 1'b0};
      end
    end
  endtask

  function automatic int ones(input int which, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (which == 0 && sd[i]) n++;
      if (which == 1 && sr[i]) n++;
      if (which == 2 && sb[i]) n++;
    end
    return n;
  endfunction

  initial begin
    logic [71:0] w;
    int bad, t;
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle
    check_int("reset_dout", int'(dout_a), 0);
    check_int("reset_busy", int'(busy_a), 0);
    check_int("reset_ready", int'(ready_a), 1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (dout_a !== 1'b0 || busy_a !== 1'b0 || ready_a !== 1'b1) bad++;
    end
    check_int("idle_100_cycles_bad", bad, 0);

    // Single pixel 0x800001
    pq[0] = 32'h800001; vs[0] = 0; npix = 1;
    run(0, 1610);
    t = xt[0];
    check_int("single_xfer_edge", t, 1);
    decode(0, t + 1, 24, w, bad);
    check_word("single_word", w, 72'h800001);
    check_int("single_shape_bad", bad, 0);
    check_int("single_b23_high", ones(0, t + 1, t + 25), 16);
    check_int("single_latch_low", ones(0, t + 601, t + 1600), 0);
    check_int("single_ready_inflight", ones(1, t, t + 1599), 1);
    check_int("single_ready_lastcycle", int'(sr[t + 599]), 1);
    check_int("single_ready_back", int'(sr[t + 1600]), 1);
    check_int("single_busy_span", ones(2, t, t + 1599), 1600);
    check_int("single_busy_fall", int'(sb[t + 1600]), 0);

    // Three back-to-back pixels
    pq[0] = 32'hFFFFFF; pq[1] = 32'h000000; pq[2] = 32'hA5A5A5;
    vs[0] = 0; vs[1] = 0; vs[2] = 0; npix = 3;
    run(0, 2810);
    check_int("b2b_count", nx, 3);
    check_int("b2b_xfer1", xt[1] - xt[0], 600);
    check_int("b2b_xfer2", xt[2] - xt[1], 600);
    decode(0, xt[0] + 1, 72, w, bad);
    check_word("b2b_words", w, 72'hFFFFFF000000A5A5A5);
    check_int("b2b_shape_bad", bad, 0);
    t = xt[2];
    check_int("b2b_latch_low", ones(0, t + 601, t + 1600), 0);
    check_int("b2b_ready_latch", ones(1, t + 600, t + 1599), 0);
    check_int("b2b_ready_back", int'(sr[t + 1600]), 1);

    // valid raised at latch cycle 500 waits for idle
    pq[0] = 32'h00FF00; pq[1] = 32'h123456;
    vs[0] = 0; vs[1] = 1101; npix = 2;
    run(0, 3210);
    check_int("latch_count", nx, 2);
    check_int("latch_ready_held", ones(1, 1101, 1600), 0);
    check_int("latch_xfer_edge", xt[1], 1602);
    decode(0, xt[1] + 1, 24, w, bad);
    check_word("latch_word", w, 72'h123456);
    check_int("latch_shape_bad", bad, 0);

    // Async reset while dout high in bit 10
    pq[0] = 32'hFFFFFF; vs[0] = 0; npix = 1;
    run(0, 332);
    check_int("rst_pre_dout", int'(dout_a), 1);
    #2 rst = 1'b1;
    #1;
    check_int("rst_async_dout", int'(dout_a), 0);
    check_int("rst_busy", int'(busy_a), 0);
    @(posedge clk); #1 rst = 1'b0;
    check_int("rst_ready", int'(ready_a), 1);
    pq[0] = 32'h5A5A5A;
    run(0, 700);
    check_int("rst_xfer_edge", xt[0], 1);
    decode(0, xt[0] + 1, 24, w, bad);
    check_word("rst_next_word", w, 72'h5A5A5A);
    check_int("rst_next_shape_bad", bad, 0);

    // Fast timing instance
    pq[0] = 32'h000003; vs[0] = 0; npix = 1;
    run(1, 160);
    t = xt[0];
    decode(1, t + 1, 24, w, bad);
    check_word("fast_word", w, 72'h000003);
    check_int("fast_shape_bad", bad, 0);
    check_int("fast_b0_high", ones(0, t + 1, t + 6), 2);
    check_int("fast_last_high", ones(0, t + 139, t + 144), 4);
    check_int("fast_latch_low", ones(0, t + 145, t + 154), 0);
    check_int("fast_ready_inflight", ones(1, t, t + 153), 1);
    check_int("fast_ready_back", int'(sr[t + 154]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
